pcmcia_host_initiator: RTL

Host-side initiator for the 8-bit PC Card / CompactFlash bus that our card firmware answers on. It turns a single-entry command interface into attribute-memory, common-memory and I/O read/write cycles with programmable setup, strobe and hold timing. It honours WAIT, samples INPACK on I/O reads, and sequences card RESET. It is used on the host/bench side of the interface and for loopback bring-up against the card logic.

---
 rtl/pcmcia_host_initiator.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pcmcia_host_initiator.sv
// Host-side initiator for the 8-bit PC Card / CompactFlash bus: card reset sequencing
// plus attribute/common memory and I/O cycles with programmable setup/strobe/hold timing.
//
// state   | meaning
// POR     | first cycle after RESETB release
// RST     | card RESET held high for RST_CYCLES
// RDYWAIT | waiting for READY, bounded by READY_TIMEOUT
// IDLE    | cmd_ready high, waiting for a command
// SETUP   | address, CE1, REG (and write data) valid before the strobe
// STROBE  | one strobe low, extended while WAIT is low
// HOLD    | address/data held after the strobe rises
// DONE    | one-cycle completion pulse
module pcmcia_host_initiator #(
  parameter int T_SETUP       = 2,
  parameter int T_STROBE      = 6,
  parameter int T_HOLD        = 2,
  parameter int WAIT_TIMEOUT  = 1024,
  parameter int RST_CYCLES    = 260,
  parameter int READY_TIMEOUT = 65535
) (
  input  logic        clk_26,
  input  logic        RESETB,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_write,
  input  logic        cmd_attr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        CE1,
  output logic        CE2,
  output logic        REG,
  output logic        OE,
  output logic        WE,
  output logic        IORD,
  output logic        IOWR,
  output logic        RESET,
  input  logic        WAIT,
  input  logic        INPACK,
  input  logic        READY
);

  localparam int CNT_W  = 17;
  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [2:0] S_POR     = 3'd0;
  localparam logic [2:0] S_RST     = 3'd1;
  localparam logic [2:0] S_RDYWAIT = 3'd2;
  localparam logic [2:0] S_IDLE    = 3'd3;
  localparam logic [2:0] S_SETUP   = 3'd4;
  localparam logic [2:0] S_STROBE  = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        op_q, op_d;
  logic              wr_q, wr_d;
  logic              rstcmd_q, rstcmd_d;
  logic [15:0]       a_q, a_d;
  logic [7:0]        dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              ce1_q, ce1_d;
  logic              reg_q, reg_d;
  logic              oe_q, oe_d, we_q, we_d, iord_q, iord_d, iowr_q, iowr_d;
  logic              reset_q, reset_d;
  logic              ready_q, ready_d;
  logic              rv_q, rv_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              op_is_write;

  assign op_is_write = (op_q == 2'b01) || ((op_q == 2'b10) && wr_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    op_d     = op_q;
    wr_d     = wr_q;
    rstcmd_d = rstcmd_q;
    a_d      = a_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    ce1_d    = ce1_q;
    reg_d    = reg_q;
    oe_d     = oe_q;
    we_d     = we_q;
    iord_d   = iord_q;
    iowr_d   = iowr_q;
    reset_d  = reset_q;
    ready_d  = ready_q;
    rv_d     = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_POR: begin
        state_d  = S_RST;
        cnt_d    = CNT_W'(RST_CYCLES - 1);
        reset_d  = 1'b1;
        rstcmd_d = 1'b0;
      end
      S_RST: begin
        if (cnt_q == '0) begin
          reset_d = 1'b0;
          state_d = S_RDYWAIT;
          cnt_d   = CNT_W'(READY_TIMEOUT - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RDYWAIT: begin
        if (READY || (cnt_q == '0)) begin
          // Only a commanded reset reports completion; power-on goes straight to IDLE.
          if (rstcmd_q) begin
            state_d = S_DONE;
            err_d   = READY ? 2'b00 : 2'b11;
          end else begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          ready_d = 1'b0;
          op_d    = cmd_op;
          wr_d    = cmd_write;
          wcnt_d  = '0;
          if (cmd_op == 2'b11) begin
            state_d  = S_RST;
            cnt_d    = CNT_W'(RST_CYCLES - 1);
            reset_d  = 1'b1;
            rstcmd_d = 1'b1;
          end else begin
            state_d  = S_SETUP;
            cnt_d    = CNT_W'(T_SETUP - 1);
            rstcmd_d = 1'b0;
            a_d      = cmd_addr;
            ce1_d    = 1'b0;
            reg_d    = (cmd_op == 2'b10) ? 1'b0 : ~cmd_attr;
            if ((cmd_op == 2'b01) || ((cmd_op == 2'b10) && cmd_write)) begin
              dout_d = cmd_wdata;
              doe_d  = 1'b1;
            end
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = CNT_W'(T_STROBE - 1);
          case (op_q)
            2'b00:   oe_d = 1'b0;
            2'b01:   we_d = 1'b0;
            default: if (wr_q) iowr_d = 1'b0; else iord_d = 1'b0;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!WAIT && (wcnt_q != WCNT_W'(WAIT_TIMEOUT))) begin
          wcnt_d = wcnt_q + 1'b1;
        end else begin
          // Strobe rises here; WAIT still low means the extension budget ran out.
          oe_d    = 1'b1;
          we_d    = 1'b1;
          iord_d  = 1'b1;
          iowr_d  = 1'b1;
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
          if (!op_is_write) rdata_d = D_in;
          if (!WAIT)                                  err_d = 2'b01;
          else if ((op_q == 2'b10) && !wr_q && INPACK) err_d = 2'b10;
          else                                        err_d = 2'b00;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ce1_d   = 1'b1;
          reg_d   = 1'b1;
          doe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        rv_d    = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_POR;
    endcase
  end

  always_ff @(posedge clk_26 or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= S_POR;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      op_q     <= 2'b00;
      wr_q     <= 1'b0;
      rstcmd_q <= 1'b0;
      a_q      <= 16'h0000;
      dout_q   <= 8'h00;
      doe_q    <= 1'b0;
      ce1_q    <= 1'b1;
      reg_q    <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      iord_q   <= 1'b1;
      iowr_q   <= 1'b1;
      reset_q  <= 1'b1;
      ready_q  <= 1'b0;
      rv_q     <= 1'b0;
      rdata_q  <= 8'h00;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      op_q     <= op_d;
      wr_q     <= wr_d;
      rstcmd_q <= rstcmd_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      ce1_q    <= ce1_d;
      reg_q    <= reg_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      iord_q   <= iord_d;
      iowr_q   <= iowr_d;
      reset_q  <= reset_d;
      ready_q  <= ready_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign A         = a_q;
  assign D_out     = dout_q;
  assign D_oe      = doe_q;
  assign CE1       = ce1_q;
  assign CE2       = 1'b1;
  assign REG       = reg_q;
  assign OE        = oe_q;
  assign WE        = we_q;
  assign IORD      = iord_q;
  assign IOWR      = iowr_q;
  assign RESET     = reset_q;

endmodule
